// File: rtl/screen_reader_resp_handshake.sv
// Four-phase request/response handshake between a hardware requester and the Nios
// screen-reader firmware, with a timeout guard on every wait state.
`default_nettype none

module screen_reader_resp_handshake #(
  parameter int REQ_W          = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int CNT_W          = 20
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  input  logic [REQ_W-1:0] req_code,
  output logic             req_ready,
  input  logic [2:0]       resp_port,
  output logic [REQ_W:0]   nios_req_port,
  output logic             nios_irq,
  output logic             resp_valid,
  output logic [2:0]       resp_code,
  output logic             resp_timeout,
  input  logic             resp_ready,
  output logic             busy,
  output logic [7:0]       timeout_count
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STALE   = 3'd1,
    POST    = 3'd2,
    DELIVER = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;
  logic             resp_seen;
  logic             wait_expired;
  logic [7:0]       timeout_count_inc;

  assign resp_seen         = (resp_port != 3'd0);
  assign wait_expired      = (wait_cnt == CNT_LAST);
  assign timeout_count_inc = (timeout_count == 8'hFF) ? timeout_count : timeout_count + 8'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      req_ready     <= 1'b1;
      nios_req_port <= '0;
      nios_irq      <= 1'b0;
      resp_valid    <= 1'b0;
      resp_code     <= 3'd0;
      resp_timeout  <= 1'b0;
      busy          <= 1'b0;
      timeout_count <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wait_cnt      <= '0;
            req_ready     <= 1'b0;
            busy          <= 1'b1;
            nios_req_port <= {~resp_seen, req_code};
            // A leftover nonzero response must be cleared before the Nios sees the new request.
            if (resp_seen) begin
              state <= STALE;
            end else begin
              state    <= POST;
              nios_irq <= 1'b1;
            end
          end
        end

        STALE: begin
          if (!resp_seen) begin
            state                <= POST;
            wait_cnt             <= '0;
            nios_irq             <= 1'b1;
            nios_req_port[REQ_W] <= 1'b1;
          end else if (wait_expired) begin
            state         <= DELIVER;
            wait_cnt      <= '0;
            resp_valid    <= 1'b1;
            resp_code     <= 3'd0;
            resp_timeout  <= 1'b1;
            timeout_count <= timeout_count_inc;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        POST: begin
          // A response arriving on the last permitted cycle beats the timeout.
          if (resp_seen || wait_expired) begin
            state                <= DELIVER;
            wait_cnt             <= '0;
            nios_irq             <= 1'b0;
            nios_req_port[REQ_W] <= 1'b0;
            resp_valid           <= 1'b1;
            resp_code            <= resp_seen ? resp_port : 3'd0;
            resp_timeout         <= ~resp_seen;
            if (!resp_seen) timeout_count <= timeout_count_inc;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        DELIVER: begin
          if (resp_ready) begin
            state      <= RELEASE;
            wait_cnt   <= '0;
            resp_valid <= 1'b0;
          end
        end

        RELEASE: begin
          if (!resp_seen || wait_expired) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
            if (resp_seen) timeout_count <= timeout_count_inc;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        default: begin
          state      <= IDLE;
          wait_cnt   <= '0;
          nios_irq   <= 1'b0;
          resp_valid <= 1'b0;
          busy       <= 1'b0;
          req_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_screen_reader_resp_handshake.sv
// Directed bench for screen_reader_resp_handshake with TIMEOUT_CYCLES=16.
`default_nettype none

module tb_screen_reader_resp_handshake;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       req_valid;
  logic [7:0] req_code;
  logic       req_ready;
  logic [2:0] resp_port;
  logic [8:0] nios_req_port;
  logic       nios_irq;
  logic       resp_valid;
  logic [2:0] resp_code;
  logic       resp_timeout;
  logic       resp_ready;
  logic       busy;
  logic [7:0] timeout_count;

  int errors = 0;
  int checks = 0;

  screen_reader_resp_handshake #(
    .REQ_W(8), .TIMEOUT_CYCLES(16), .CNT_W(5)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_code(req_code), .req_ready(req_ready),
    .resp_port(resp_port), .nios_req_port(nios_req_port), .nios_irq(nios_irq),
    .resp_valid(resp_valid), .resp_code(resp_code), .resp_timeout(resp_timeout),
    .resp_ready(resp_ready), .busy(busy), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".req_ready"}, req_ready, 1);
    check_eq({tag, ".busy"}, busy, 0);
    check_eq({tag, ".irq"}, nios_irq, 0);
    check_eq({tag, ".resp_valid"}, resp_valid, 0);
  endtask

  initial begin
    int irq_cycles;
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_code   = 8'h00;
    resp_port  = 3'd0;
    resp_ready = 1'b1;
    #12;
    check_eq("rst.nios_req_port", nios_req_port, 9'h000);
    check_eq("rst.resp_code", resp_code, 0);
    check_eq("rst.resp_timeout", resp_timeout, 0);
    check_eq("rst.timeout_count", timeout_count, 0);
    check_idle_outputs("rst");
    reset_n = 1'b1;
    step();

    // 1: normal handshake
    req_valid = 1'b1; req_code = 8'h5A;
    step();
    req_valid = 1'b0; req_code = 8'hFF;
    check_eq("t1.irq_T1", nios_irq, 1);
    check_eq("t1.nios_req_port", nios_req_port, 9'h15A);
    check_eq("t1.req_ready", req_ready, 0);
    check_eq("t1.busy", busy, 1);
    step(); step();
    check_eq("t1.nios_req_port_hold", nios_req_port, 9'h15A);
    resp_port = 3'd5;
    step();
    check_eq("t1.resp_valid", resp_valid, 1);
    check_eq("t1.resp_code", resp_code, 5);
    check_eq("t1.resp_timeout", resp_timeout, 0);
    check_eq("t1.irq_off", nios_irq, 0);
    check_eq("t1.pending_off", nios_req_port, 9'h05A);
    step();
    check_eq("t1.resp_valid_drop", resp_valid, 0);
    check_eq("t1.busy_release", busy, 1);
    resp_port = 3'd0;
    step();
    check_idle_outputs("t1.done");
    check_eq("t1.timeout_count", timeout_count, 0);

    // 2: stale response at accept
    req_valid = 1'b1; req_code = 8'h33; resp_port = 3'd2;
    step();
    req_valid = 1'b0;
    check_eq("t2.stale_irq", nios_irq, 0);
    check_eq("t2.stale_port", nios_req_port, 9'h033);
    check_eq("t2.stale_busy", busy, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t2.stale_irq_hold", nios_irq, 0);
    end
    resp_port = 3'd0;
    step();
    check_eq("t2.post_irq", nios_irq, 1);
    check_eq("t2.post_port", nios_req_port, 9'h133);
    resp_port = 3'd6;
    step();
    check_eq("t2.resp_valid", resp_valid, 1);
    check_eq("t2.resp_code", resp_code, 6);
    step();
    resp_port = 3'd0;
    step();
    check_idle_outputs("t2.done");

    // 3: POST timeout
    req_valid = 1'b1; req_code = 8'hC3;
    step();
    req_valid = 1'b0;
    irq_cycles = 0;
    for (int i = 0; i < 40 && nios_irq; i++) begin
      irq_cycles++;
      step();
    end
    check_eq("t3.irq_cycles", irq_cycles, 16);
    check_eq("t3.resp_valid", resp_valid, 1);
    check_eq("t3.resp_code", resp_code, 0);
    check_eq("t3.resp_timeout", resp_timeout, 1);
    check_eq("t3.timeout_count", timeout_count, 1);
    step();
    check_eq("t3.resp_valid_drop", resp_valid, 0);
    step();
    check_idle_outputs("t3.done");

    // 4: backpressure while resp_port changes underneath DELIVER
    resp_ready = 1'b0;
    req_valid = 1'b1; req_code = 8'h11;
    step();
    req_valid = 1'b0;
    resp_port = 3'd5;
    step();
    for (int i = 0; i < 10; i++) begin
      resp_port = (i < 4) ? 3'd5 : (i < 7) ? 3'd0 : 3'd7;
      step();
      check_eq("t4.held_valid", resp_valid, 1);
      check_eq("t4.held_code", resp_code, 5);
    end
    resp_ready = 1'b1;
    step();
    check_eq("t4.release_valid", resp_valid, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t4.release_busy", busy, 1);
    end
    resp_port = 3'd0;
    step();
    check_idle_outputs("t4.done");

    // 5: response on the last permitted POST cycle beats the timeout
    req_valid = 1'b1; req_code = 8'h22;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      step();
      check_eq("t5.irq_hold", nios_irq, 1);
    end
    resp_port = 3'd1;
    step();
    check_eq("t5.resp_valid", resp_valid, 1);
    check_eq("t5.resp_code", resp_code, 1);
    check_eq("t5.resp_timeout", resp_timeout, 0);
    check_eq("t5.timeout_count", timeout_count, 1);
    step();
    resp_port = 3'd0;
    step();
    check_idle_outputs("t5.done");

    // 6: asynchronous reset mid-POST
    req_valid = 1'b1; req_code = 8'h44;
    step();
    req_valid = 1'b0;
    check_eq("t6.irq_before", nios_irq, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t6.rst_port", nios_req_port, 9'h000);
    check_eq("t6.rst_code", resp_code, 0);
    check_eq("t6.rst_timeout", resp_timeout, 0);
    check_eq("t6.rst_timeout_count", timeout_count, 0);
    check_idle_outputs("t6.rst");
    #3 reset_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check_eq("t6.no_resp_valid", resp_valid, 0);
      check_eq("t6.req_ready", req_ready, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
